// File: rtl/layer_out_serializer.sv
// layer_out_serializer: captures a parallel layer output frame and replays it one word per cycle.
// Optional LAYER_SER_ERR_EN builds a sticky overrun/partial-valid error flag.
module layer_out_serializer #(
   parameter int numNeurons = 30,
   parameter int dataWidth  = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [numNeurons-1:0]           x_valid,
   input  logic [numNeurons*dataWidth-1:0] x_in,
   output logic [dataWidth-1:0]            data_out,
   output logic                            data_out_valid,
   output logic                            busy,
   output logic                            frame_done,
   output logic                            err
);
   localparam int CW = $clog2(numNeurons);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [dataWidth-1:0] buf_q [numNeurons];
   logic last, capture, accept;
   assign last    = cnt == CW'(numNeurons - 1);
   assign capture = &x_valid;
   assign accept  = capture && (state == IDLE || last);
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (accept) begin
         state_nx = SHIFT;
         cnt_nx   = '0;
      end else if (state == SHIFT) begin
         state_nx = last ? IDLE : SHIFT;
         cnt_nx   = last ? '0 : cnt + 1'b1;
      end
   end
   // data_out is preloaded one slot ahead so it shows buf_q[cnt] in the same cycle as cnt
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         data_out <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (accept)
            data_out <= x_in[0 +: dataWidth];
         else if (state == SHIFT && !last)
            data_out <= buf_q[cnt + 1'b1];
      end
   end
   always_ff @(posedge clk)
      if (accept)
         for (int i = 0; i < numNeurons; i++)
            buf_q[i] <= x_in[i*dataWidth +: dataWidth];
   assign data_out_valid = state == SHIFT;
   assign busy           = state == SHIFT;
   assign frame_done     = busy && last;
`ifdef LAYER_SER_ERR_EN
   always_ff @(posedge clk)
      if (rst)
         err <= 1'b0;
      else if ((capture && !accept) || (|x_valid && !capture))
         err <= 1'b1;
`else
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_layer_out_serializer.sv
// tb_layer_out_serializer: scoreboard bench for layer_out_serializer (default parameters).
module tb_layer_out_serializer;
   localparam int N = 30;
   localparam int W = 16;
   typedef struct {
      logic [W-1:0] w;
      logic         l;
   } exp_t;
   logic clk = 1'b0;
   logic rst;
   logic [N-1:0] x_valid;
   logic [N*W-1:0] x_in;
   logic [W-1:0] data_out;
   logic data_out_valid, busy, frame_done, err;
   exp_t q[$];
   int n_checks = 0;
   int n_pass = 0;
   logic err_m;
   logic [W-1:0] last_out;
   localparam logic [N-1:0] ALL = '1;
   layer_out_serializer #(.numNeurons(N), .dataWidth(W)) dut (
      .clk(clk), .rst(rst), .x_valid(x_valid), .x_in(x_in),
      .data_out(data_out), .data_out_valid(data_out_valid), .busy(busy),
      .frame_done(frame_done), .err(err)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
   endtask
   function automatic logic [N*W-1:0] frame(input logic [W-1:0] base);
      logic [N*W-1:0] f;
      for (int i = 0; i < N; i++) f[i*W +: W] = base + W'(i);
      return f;
   endfunction
   function automatic logic [N*W-1:0] rand_frame();
      logic [N*W-1:0] f;
      for (int i = 0; i < N; i++) f[i*W +: W] = W'($urandom);
      return f;
   endfunction
   // one clock cycle: drive inputs, advance the scoreboard, then check this cycle's outputs
   task automatic step(input logic r, input logic [N-1:0] v, input logic [N*W-1:0] x);
      logic err_nx;
      exp_t e;
      rst = r;
      x_valid = v;
      x_in = x;
      err_nx = 1'b0;
      if (r) q.delete();
      else begin
`ifdef LAYER_SER_ERR_EN
         err_nx = err_m | (&v && q.size() != 0) | (|v && !(&v));
`endif
         if (&v && q.size() == 0)
            for (int i = 0; i < N; i++) q.push_back('{x[i*W +: W], i == N - 1});
      end
      @(posedge clk);
      #1;
      err_m = err_nx;
      if (r) last_out = '0;
      if (q.size() > 0) begin
         e = q.pop_front();
         check("valid", 32'(data_out_valid), 32'd1);
         check("data", 32'(data_out), 32'(e.w));
         check("frame_done", 32'(frame_done), 32'(e.l));
         check("busy", 32'(busy), 32'd1);
         last_out = e.w;
      end else begin
         check("idle_valid", 32'(data_out_valid), 32'd0);
         check("idle_busy", 32'(busy), 32'd0);
         check("idle_frame_done", 32'(frame_done), 32'd0);
         check("idle_hold", 32'(data_out), 32'(last_out));
      end
      check("err", 32'(err), 32'(err_m));
   endtask
   initial begin
      logic [N*W-1:0] sf;
      logic [N-1:0] v;
      int r;
      rst = 1'b1;
      x_valid = '0;
      x_in = '0;
      err_m = 1'b0;
      last_out = '0;
      step(1, '0, '0);
      step(1, '0, '0);
      repeat (3) step(0, '0, '0);
      step(0, ALL, frame(16'h0100));
      for (int i = 1; i < N; i++)
         step(0, i == 5 ? ALL : '0, i == 5 ? {N{16'hFFFF}} : '0);
      step(0, ALL, frame(16'h0200));
      repeat (32) step(0, '0, '0);
      step(0, N'(1), '0);
      repeat (2) step(0, '0, '0);
      step(0, ALL, frame(16'h0300));
      repeat (14) step(0, '0, '0);
      step(1, '0, '0);
      repeat (4) step(0, '0, '0);
      sf = frame(16'h0400);
      sf[0 +: W] = 16'h8000;
      sf[(N-1)*W +: W] = 16'h7FFF;
      step(0, ALL, sf);
      repeat (31) step(0, '0, '0);
      repeat (400) begin
         r = $urandom_range(0, 63);
         v = r < 12 ? ALL : r < 15 ? N'($urandom) : '0;
         step(r == 63, v, rand_frame());
      end
      repeat (N + 2) step(0, '0, '0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/layer_out_serializer.md
# layer_out_serializer

Downstream collector for one fully connected layer. It captures the parallel `out` words of all `numNeurons` neurons in the same cycle their `outvalid` strobes assert. It then replays those words one per cycle, in neuron-index order, as the serial `myinput`/`myinputValid` stream broadcast to every neuron of the next layer. It sits between layer N's neuron array and layer N+1's neuron array, and its serial length equals the next layer's `numWeight`.

## Interface
Parameters:
- `numNeurons`, 30: neurons in the producing layer, and words per frame.
- `dataWidth`, 16: width of each neuron output word.

Ports:
- `clk`, input, 1: the single clock; all logic is on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `x_valid`, input, `numNeurons`: per-neuron `outvalid`; bit i belongs to neuron i.
- `x_in`, input, `numNeurons*dataWidth`: packed neuron outputs; neuron i occupies bits `[i*dataWidth +: dataWidth]`.
- `data_out`, output, `dataWidth`: serial word, connected to the next layer's `myinput`.
- `data_out_valid`, output, 1: word strobe, connected to the next layer's `myinputValid`.
- `busy`, output, 1: high while a frame is being replayed.
- `frame_done`, output, 1: one-cycle pulse, coincident with the last word of a frame.
- `err`, output, 1: sticky error flag (see Configuration).

## Operation
- The block is clocked by `clk` and reset by `rst`. Reset is synchronous and active-high.
- **Capture condition:** `capture = &x_valid`, accepted only when `state==IDLE`, or when `state==SHIFT && cnt==numNeurons-1`.
- **On capture:**
  - all `numNeurons` words are latched into an internal buffer;
  - `cnt` is set to 0;
  - `state` becomes SHIFT.
- **State machine:**
  - IDLE → SHIFT on an accepted capture.
  - SHIFT, `cnt<numNeurons-1`: stays in SHIFT and increments `cnt`.
  - SHIFT, `cnt==numNeurons-1` with an accepted capture: reloads the buffer, `cnt` returns to 0, stays in SHIFT. This gives gapless back-to-back frames.
  - SHIFT, `cnt==numNeurons-1` without a capture: returns to IDLE.
- **Output in SHIFT:** `data_out = buf[cnt]` and `data_out_valid=1`, both registered.
- **Output in IDLE:** `data_out_valid=0` and `data_out` holds its last value.
- **Counter width:** `cnt` is `$clog2(numNeurons)` bits and never wraps past `numNeurons-1`.
- **Word content:** words pass through bit-exact, with no arithmetic and no sign handling.
- **`frame_done`:** equals `data_out_valid && cnt==numNeurons-1`.
- **`busy`:** equals `state==SHIFT`.
- **Overrun** (`capture` while in SHIFT with `cnt<numNeurons-1`):
  - the new frame is dropped;
  - the current replay continues unchanged.
- **Partial valid** (`|x_valid && !&x_valid`):
  - nothing is captured;
  - the cycle is treated as an error event.
- **Reset mid-frame:** the replay is aborted. The cycle after `rst` is sampled high must show `data_out_valid=0`; no stale words are emitted.

## Timing
- **Reset values:**
  - `data_out=0`
  - `data_out_valid=0`
  - `busy=0`
  - `frame_done=0`
  - `err=0`
  - state is IDLE and `cnt=0`.
- **Latency:** `x_valid` all-high in cycle T gives:
  - neuron 0's word on `data_out` with `data_out_valid=1` in cycle T+1;
  - neuron k's word in cycle T+1+k;
  - the last word and the `frame_done` pulse in cycle T+`numNeurons`.
- **Throughput:** one frame per `numNeurons` cycles when captures arrive exactly in each frame's last cycle.
- **Capture timing:**
  - the earliest accepted re-capture is in cycle T+`numNeurons`;
  - a capture in any of cycles T+1..T+`numNeurons`-1 is an overrun.
- **No backpressure:** the next layer consumes every word on the cycle it is valid.

## Configuration
- Macro: `LAYER_SER_ERR_EN`.
- **Defined:**
  - `err` is set on any overrun or partial-valid cycle;
  - it is cleared only by `rst`;
  - the flag is registered, so it rises the cycle after the offending event.
- **Undefined:**
  - `err` is tied to 0 and no detection logic is built;
  - overrun and partial-valid events are still silently ignored, exactly as above.

## Test plan
- **Basic frame:** reset, then in cycle 5 drive `x_valid` all-ones with word i = 0x0100+i. Required: `data_out` reads 0x0100..0x011D in cycles 6..35 with `data_out_valid` high; `frame_done` only in cycle 35; `busy` falls in cycle 36.
- **Back-to-back:** recapture in cycle 35 with words 0x0200+i. Required: cycle 36 shows 0x0200 with no valid gap; the second `frame_done` falls in cycle 65.
- **Overrun:** a second all-ones capture of 0xFFFF words in cycle 10. Required: the stream still delivers 0x0100..0x011D unchanged; `err` = 1 from cycle 11 when `LAYER_SER_ERR_EN` is defined, otherwise `err` stays 0.
- **Partial valid:** `x_valid` = 0x0000_0001 for one cycle while IDLE. Required: no `data_out_valid`; `err` = 1 the next cycle when `LAYER_SER_ERR_EN` is defined.
- **Reset mid-frame:** assert `rst` in cycle 20 of a frame. Required: cycle 21 shows `data_out_valid=0`, `busy=0`, `err=0`. A new capture in cycle 25 then replays from neuron 0 in cycle 26.
- **Signed data:** load 0x8000 into neuron 0 and 0x7FFF into neuron 29. Required: both are emitted bit-exact in the first and last frame slots.
